// File: rtl/add_word_te_seq.sv
// add_word_te_seq
//   Adds two balanced-ternary words one trit per cycle, LSB first. A single
//   trit-level add stage is reused every cycle, and a carry trit is kept
//   between cycles. Trit encoding: 2'b10 = +1, 2'b00 = 0, 2'b01 = -1,
//   2'b11 = error.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        controller idle and able to accept operands
//   a_word     in   2*TRITS  operand A, trit i at [2i+1:2i]
//   b_word     in   2*TRITS  operand B
//   out_valid  out  1        sum_word / carry_out / err valid
//   out_ready  in   1        consumer accepts result
//   sum_word   out  2*TRITS  result trits
//   carry_out  out  2        final carry trit
//   err        out  1        an operand contained an error trit
module add_word_te_seq #(
    parameter int TRITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*TRITS-1:0] a_word,
    input  logic [2*TRITS-1:0] b_word,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*TRITS-1:0] sum_word,
    output logic [1:0]         carry_out,
    output logic               err
);

    localparam int IDX_W = $clog2(TRITS);

    localparam logic [1:0] T_POS = 2'b10;
    localparam logic [1:0] T_ZER = 2'b00;
    localparam logic [1:0] T_NEG = 2'b01;
    localparam logic [1:0] T_ERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e             state_q;
    logic [2*TRITS-1:0] a_q, b_q, sum_q;
    logic [1:0]         carry_q, cout_q;
    logic               err_q, ovalid_q;
    logic [IDX_W-1:0]   idx_q;

    // Decodes a trit to a signed value; the error code is screened separately.
    function automatic logic signed [2:0] trit_val(input logic [1:0] t);
        case (t)
            T_POS:   trit_val = 3'sd1;
            T_NEG:   trit_val = -3'sd1;
            default: trit_val = 3'sd0;
        endcase
    endfunction

    // Single trit add stage working on the trit selected by idx_q.
    logic [1:0]         a_k, b_k, dig, cy;
    logic signed [2:0]  t_sum;
    logic               trit_err, last_trit;
    logic [2*TRITS-1:0] sum_dig, sum_bad;

    assign a_k       = a_q[{idx_q, 1'b0} +: 2];
    assign b_k       = b_q[{idx_q, 1'b0} +: 2];
    assign trit_err  = (a_k == T_ERR) || (b_k == T_ERR);
    assign last_trit = (idx_q == IDX_W'(TRITS - 1));
    assign t_sum     = trit_val(a_k) + trit_val(b_k) + trit_val(carry_q);

    always_comb begin
        dig = T_ZER;
        cy  = T_ZER;
        case (t_sum)
            3'b101: begin dig = T_ZER; cy = T_NEG; end  // -3
            3'b110: begin dig = T_POS; cy = T_NEG; end  // -2
            3'b111: begin dig = T_NEG; cy = T_ZER; end  // -1
            3'b001: begin dig = T_POS; cy = T_ZER; end  // +1
            3'b010: begin dig = T_NEG; cy = T_POS; end  // +2
            3'b011: begin dig = T_ZER; cy = T_POS; end  // +3
            default: begin dig = T_ZER; cy = T_ZER; end // 0
        endcase
    end

    always_comb begin
        sum_dig = sum_q;
        sum_bad = sum_q;
        sum_dig[{idx_q, 1'b0} +: 2] = dig;
        sum_bad[{idx_q, 1'b0} +: 2] = T_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= T_ZER;
            cout_q   <= T_ZER;
            err_q    <= 1'b0;
            idx_q    <= '0;
            ovalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a_word;
                        b_q     <= b_word;
                        sum_q   <= '0;
                        carry_q <= T_ZER;
                        cout_q  <= T_ZER;
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (trit_err) begin
                        // Early abort: higher trits stay zero, lower keep their digits.
                        sum_q    <= sum_bad;
                        err_q    <= 1'b1;
                        cout_q   <= T_ZER;
                        ovalid_q <= 1'b1;
                        state_q  <= HOLD;
                    end else begin
                        sum_q   <= sum_dig;
                        carry_q <= cy;
                        idx_q   <= idx_q + 1'b1;
                        if (last_trit) begin
                            cout_q   <= cy;
                            ovalid_q <= 1'b1;
                            state_q  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        ovalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Held low while reset is asserted even though the state already reads IDLE.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = ovalid_q;
    assign sum_word  = sum_q;
    assign carry_out = cout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_add_word_te_seq.sv
module tb_add_word_te_seq;

    localparam int TRITS = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2*TRITS-1:0] a_word, b_word;
    logic             out_valid;
    logic             out_ready;
    logic [2*TRITS-1:0] sum_word;
    logic [1:0]       carry_out;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;

    add_word_te_seq #(.TRITS(TRITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_word    (a_word),
        .b_word    (b_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_word  (sum_word),
        .carry_out (carry_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One operation: accept, scramble inputs during RUN, check latency and result.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] e_sum, input logic [1:0] e_cout,
                          input logic e_err, input int e_lat);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, in_ready, 1'b1);
        in_valid  = 1'b1;
        a_word    = a;
        b_word    = b;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a_word   = 8'hFF;   // operands must already be latched
        b_word   = 8'hFF;
        chk({tag, ".run_busy"}, in_ready, 1'b0);
        wait_result(lat);
        chk({tag, ".latency"}, lat, e_lat);
        chk({tag, ".sum"}, sum_word, e_sum);
        chk({tag, ".cout"}, carry_out, e_cout);
        chk({tag, ".err"}, err, e_err);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".drop"}, out_valid, 1'b0);
    endtask

    initial begin
        int lat;
        int spurious;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_word = '0; b_word = '0;
        repeat (2) @(negedge clk);
        chk("rst.in_ready", in_ready, 1'b0);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.sum", sum_word, 8'h00);
        chk("rst.cout", carry_out, 2'b00);
        chk("rst.err", err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        //      tag       a      b      sum    cout   err lat
        run_op("p1p1",  8'h02, 8'h02, 8'h09, 2'b00, 0, 4); // 1+1 = 3-1
        run_op("all_p", 8'hAA, 8'hAA, 8'h01, 2'b10, 0, 4); // 80 = 81-1
        run_op("m1p1",  8'h01, 8'h02, 8'h00, 2'b00, 0, 4);
        run_op("all_m", 8'h55, 8'h55, 8'h02, 2'b01, 0, 4); // -80 = -81+1
        run_op("cancel",8'hAA, 8'h55, 8'h00, 2'b00, 0, 4);
        run_op("err2",  8'h32, 8'h02, 8'h39, 2'b00, 1, 3);
        run_op("err0",  8'h03, 8'h00, 8'h03, 2'b00, 1, 1);
        run_op("err3b", 8'h02, 8'hC0, 8'hC2, 2'b00, 1, 4);
        run_op("after_err", 8'h02, 8'h00, 8'h02, 2'b00, 0, 4);

        // Backpressure: stall in HOLD while a new pair is offered.
        @(negedge clk);
        in_valid = 1'b1; a_word = 8'h02; b_word = 8'h02; out_ready = 1'b0;
        @(negedge clk);
        a_word = 8'hAA; b_word = 8'hAA;   // next pair, held valid
        wait_result(lat);
        chk("bp.latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.out_valid", out_valid, 1'b1);
            chk("bp.in_ready", in_ready, 1'b0);
            chk("bp.sum", sum_word, 8'h09);
            chk("bp.cout", carry_out, 2'b00);
        end
        out_ready = 1'b1;
        @(negedge clk);           // handshake edge passed, now IDLE
        out_ready = 1'b0;
        chk("bp.release", out_valid, 1'b0);
        chk("bp.idle", in_ready, 1'b1);
        @(negedge clk);           // second pair accepted
        in_valid = 1'b0;
        chk("bp.accepted", in_ready, 1'b0);
        wait_result(lat);
        chk("bp2.latency", lat, 4);
        chk("bp2.sum", sum_word, 8'h01);
        chk("bp2.cout", carry_out, 2'b10);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset mid-RUN.
        @(negedge clk);
        in_valid = 1'b1; a_word = 8'hAA; b_word = 8'hAA;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rrun.in_ready", in_ready, 1'b0);
        chk("rrun.out_valid", out_valid, 1'b0);
        chk("rrun.sum", sum_word, 8'h00);
        chk("rrun.err", err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rrun.idle", in_ready, 1'b1);
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        chk("rrun.no_result", spurious, 0);
        chk("rrun.sum_after", sum_word, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
